// File: rtl/book_pkg.sv
// Shared encodings for the price-level book: tick types, FSM states and
// the per-side empty-level price sentinels.
package book_pkg;

    localparam logic [1:0] TICK_ADD    = 2'b00;
    localparam logic [1:0] TICK_EXEC   = 2'b01;
    localparam logic [1:0] TICK_CANCEL = 2'b10;
    localparam logic [1:0] TICK_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_APPLY = 2'd2
    } book_state_e;

    // Sentinels are returned wide and truncated by the caller to its PX_W.
    function automatic logic [127:0] invalid_bid_px(input int unsigned w);
        return 128'(0) & ({128{1'b1}} >> (128 - w));
    endfunction

    function automatic logic [127:0] invalid_ask_px(input int unsigned w);
        return {128{1'b1}} >> (128 - w);
    endfunction

endpackage

// File: rtl/book_levels_if.sv
// Tick handshake from the feed decoder into the book.
interface book_levels_if #(
    parameter int PX_W  = 32,
    parameter int QTY_W = 32
);
    logic             tick_valid;
    logic             tick_ready;
    logic [1:0]       tick_type;
    logic             tick_side;
    logic [QTY_W-1:0] tick_qty;
    logic [PX_W-1:0]  tick_price;

    modport master (
        output tick_valid, tick_type, tick_side, tick_qty, tick_price,
        input  tick_ready
    );

    modport slave (
        input  tick_valid, tick_type, tick_side, tick_qty, tick_price,
        output tick_ready
    );
endinterface

// File: rtl/book_side.sv
// One side of the book: sorted level arrays, registered compare vectors and
// the insert (shift down) / remove (shift up) datapath.
module book_side
    import book_pkg::*;
#(
    parameter bit IS_BID = 1'b1,
    parameter int PX_W   = 32,
    parameter int QTY_W  = 32,
    parameter int DEPTH  = 8,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          match_en,
    input  logic                          apply_en,
    input  logic                          op_add,
    input  logic [PX_W-1:0]               t_px,
    input  logic [QTY_W-1:0]              t_qty,
    output logic [DEPTH-1:0][PX_W-1:0]    px_arr,
    output logic [DEPTH-1:0][QTY_W-1:0]   sz_arr,
    output logic [CW-1:0]                 cnt,
    output logic                          hit,
    output logic                          ins,
    output logic                          full
);
    localparam logic [PX_W-1:0] SENT = IS_BID ? PX_W'(invalid_bid_px(PX_W))
                                              : PX_W'(invalid_ask_px(PX_W));

    logic [DEPTH-1:0] eq_c, better_c, eq_q, better_q;
    logic [DEPTH-1:0] first_better, at_or_below;
    logic [DEPTH-1:0][PX_W-1:0]  px_n, up_px, dn_px;
    logic [DEPTH-1:0][QTY_W-1:0] sz_n, up_sz, dn_sz;
    logic [QTY_W-1:0] hit_sz, sat_sz;
    logic [QTY_W:0]   sum;
    logic [CW-1:0]    cnt_n;
    logic             remove_lvl;

    // Empty levels always compare as worse, so better_c is a thermometer
    // and its lowest set bit is the insertion point.
    always_comb begin
        eq_c     = '0;
        better_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt) begin
                eq_c[i]     = (px_arr[i] == t_px);
                better_c[i] = IS_BID ? (t_px > px_arr[i]) : (t_px < px_arr[i]);
            end else begin
                better_c[i] = 1'b1;
            end
        end
    end

    assign hit  = |eq_q;
    assign ins  = |better_q;
    assign full = (cnt == CW'(DEPTH));

    assign up_px = {SENT, px_arr[DEPTH-1:1]};
    assign up_sz = {QTY_W'(0), sz_arr[DEPTH-1:1]};
    assign dn_px = {px_arr[DEPTH-2:0], t_px};
    assign dn_sz = {sz_arr[DEPTH-2:0], t_qty};
    assign first_better = better_q & ~{better_q[DEPTH-2:0], 1'b0};

    always_comb begin
        hit_sz = '0;
        for (int i = 0; i < DEPTH; i++)
            if (eq_q[i]) hit_sz = hit_sz | sz_arr[i];
        sum        = {1'b0, hit_sz} + {1'b0, t_qty};
        sat_sz     = sum[QTY_W] ? '1 : sum[QTY_W-1:0];
        remove_lvl = !op_add && hit && (t_qty >= hit_sz);

        at_or_below[0] = eq_q[0];
        for (int i = 1; i < DEPTH; i++)
            at_or_below[i] = at_or_below[i-1] | eq_q[i];

        px_n  = px_arr;
        sz_n  = sz_arr;
        cnt_n = cnt;
        if (op_add) begin
            if (hit) begin
                for (int i = 0; i < DEPTH; i++)
                    if (eq_q[i]) sz_n[i] = sat_sz;
            end else if (ins) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (first_better[i]) begin
                        px_n[i] = t_px;
                        sz_n[i] = t_qty;
                    end else if (better_q[i]) begin
                        px_n[i] = dn_px[i];
                        sz_n[i] = dn_sz[i];
                    end
                end
                if (!full) cnt_n = cnt + CW'(1);
            end
        end else if (remove_lvl) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (at_or_below[i]) begin
                    px_n[i] = up_px[i];
                    sz_n[i] = up_sz[i];
                end
            end
            cnt_n = cnt - CW'(1);
        end else if (hit) begin
            for (int i = 0; i < DEPTH; i++)
                if (eq_q[i]) sz_n[i] = sz_arr[i] - t_qty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_arr   <= {DEPTH{SENT}};
            sz_arr   <= '0;
            cnt      <= '0;
            eq_q     <= '0;
            better_q <= '0;
        end else if (clear) begin
            px_arr   <= {DEPTH{SENT}};
            sz_arr   <= '0;
            cnt      <= '0;
            eq_q     <= '0;
            better_q <= '0;
        end else begin
            if (match_en) begin
                eq_q     <= eq_c;
                better_q <= better_c;
            end
            if (apply_en) begin
                px_arr <= px_n;
                sz_arr <= sz_n;
                cnt    <= cnt_n;
            end
        end
    end

endmodule

// File: rtl/book_levels.sv
// DEPTH-level order book: tick FSM, reject decode, statistics counters and
// flat snapshot packing around two book_side instances.
module book_levels
    import book_pkg::*;
#(
    parameter int PX_W  = 32,
    parameter int QTY_W = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    book_levels_if.slave           tick,
    output logic [PX_W-1:0]        bid_px0,
    output logic [QTY_W-1:0]       bid_sz0,
    output logic [PX_W-1:0]        ask_px0,
    output logic [QTY_W-1:0]       ask_sz0,
    output logic [DEPTH*PX_W-1:0]  bid_px_flat,
    output logic [DEPTH*QTY_W-1:0] bid_sz_flat,
    output logic [DEPTH*PX_W-1:0]  ask_px_flat,
    output logic [DEPTH*QTY_W-1:0] ask_sz_flat,
    output logic [CW-1:0]          bid_cnt,
    output logic [CW-1:0]          ask_cnt,
    output logic                   upd_valid,
    output logic [CNT_W-1:0]       cnt_drop,
    output logic [CNT_W-1:0]       cnt_evict,
    output logic [CNT_W-1:0]       cnt_miss,
    output logic [CNT_W-1:0]       cnt_reject
);
    localparam logic [PX_W-1:0] INV_BID = PX_W'(invalid_bid_px(PX_W));
    localparam logic [PX_W-1:0] INV_ASK = PX_W'(invalid_ask_px(PX_W));

    book_state_e       state;
    logic [1:0]        t_type;
    logic              t_side, t_rej;
    logic [QTY_W-1:0]  t_qty;
    logic [PX_W-1:0]   t_px;
    logic              in_rej, t_add;
    logic              b_hit, b_ins, b_full, a_hit, a_ins, a_full;
    logic              s_hit, s_ins, s_full;
    logic [DEPTH-1:0][PX_W-1:0]  bid_px, ask_px;
    logic [DEPTH-1:0][QTY_W-1:0] bid_sz, ask_sz;

    assign tick.tick_ready = (state == ST_IDLE) && !clear;

    assign in_rej = (tick.tick_type == TICK_RSVD) || (tick.tick_qty == '0) ||
                    ( tick.tick_side && tick.tick_price == INV_BID) ||
                    (!tick.tick_side && tick.tick_price == INV_ASK);
    assign t_add  = (t_type == TICK_ADD);

    assign s_hit  = t_side ? b_hit  : a_hit;
    assign s_ins  = t_side ? b_ins  : a_ins;
    assign s_full = t_side ? b_full : a_full;

    book_side #(.IS_BID(1'b1), .PX_W(PX_W), .QTY_W(QTY_W), .DEPTH(DEPTH)) u_bid (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .match_en(state == ST_MATCH && t_side && !t_rej),
        .apply_en(state == ST_APPLY && t_side && !t_rej),
        .op_add(t_add), .t_px(t_px), .t_qty(t_qty),
        .px_arr(bid_px), .sz_arr(bid_sz), .cnt(bid_cnt),
        .hit(b_hit), .ins(b_ins), .full(b_full)
    );

    book_side #(.IS_BID(1'b0), .PX_W(PX_W), .QTY_W(QTY_W), .DEPTH(DEPTH)) u_ask (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .match_en(state == ST_MATCH && !t_side && !t_rej),
        .apply_en(state == ST_APPLY && !t_side && !t_rej),
        .op_add(t_add), .t_px(t_px), .t_qty(t_qty),
        .px_arr(ask_px), .sz_arr(ask_sz), .cnt(ask_cnt),
        .hit(a_hit), .ins(a_ins), .full(a_full)
    );

    assign bid_px0     = bid_px[0];
    assign bid_sz0     = bid_sz[0];
    assign ask_px0     = ask_px[0];
    assign ask_sz0     = ask_sz[0];
    assign bid_px_flat = bid_px;
    assign bid_sz_flat = bid_sz;
    assign ask_px_flat = ask_px;
    assign ask_sz_flat = ask_sz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            t_type     <= TICK_ADD;
            t_side     <= 1'b0;
            t_rej      <= 1'b0;
            t_qty      <= '0;
            t_px       <= '0;
            upd_valid  <= 1'b0;
            cnt_drop   <= '0;
            cnt_evict  <= '0;
            cnt_miss   <= '0;
            cnt_reject <= '0;
        end else begin
            upd_valid <= 1'b0;
            if (clear) begin
                state     <= ST_IDLE;
                upd_valid <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (tick.tick_valid) begin
                        t_type <= tick.tick_type;
                        t_side <= tick.tick_side;
                        t_qty  <= tick.tick_qty;
                        t_px   <= tick.tick_price;
                        t_rej  <= in_rej;
                        state  <= ST_MATCH;
                    end
                    ST_MATCH: state <= ST_APPLY;
                    ST_APPLY: begin
                        state <= ST_IDLE;
                        if (t_rej) begin
                            cnt_reject <= sat_inc(cnt_reject);
                        end else if (t_add) begin
                            upd_valid <= s_hit || s_ins;
                            if (!s_hit && s_ins && s_full) cnt_evict <= sat_inc(cnt_evict);
                            if (!s_hit && !s_ins)          cnt_drop  <= sat_inc(cnt_drop);
                        end else begin
                            upd_valid <= s_hit;
                            if (!s_hit) cnt_miss <= sat_inc(cnt_miss);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_book_levels.sv
// Directed scenarios for book_levels with hand-computed expectations.
module tb_book_levels;
    localparam int PX_W = 32, QTY_W = 32, DEPTH = 8, CNT_W = 16, CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic [PX_W-1:0]        bid_px0, ask_px0;
    logic [QTY_W-1:0]       bid_sz0, ask_sz0;
    logic [DEPTH*PX_W-1:0]  bid_px_flat, ask_px_flat;
    logic [DEPTH*QTY_W-1:0] bid_sz_flat, ask_sz_flat;
    logic [CW-1:0]          bid_cnt, ask_cnt;
    logic                   upd_valid;
    logic [CNT_W-1:0]       cnt_drop, cnt_evict, cnt_miss, cnt_reject;

    int n_chk = 0;
    int n_fail = 0;

    book_levels_if #(.PX_W(PX_W), .QTY_W(QTY_W)) tif ();

    book_levels #(.PX_W(PX_W), .QTY_W(QTY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .tick(tif),
        .bid_px0(bid_px0), .bid_sz0(bid_sz0), .ask_px0(ask_px0), .ask_sz0(ask_sz0),
        .bid_px_flat(bid_px_flat), .bid_sz_flat(bid_sz_flat),
        .ask_px_flat(ask_px_flat), .ask_sz_flat(ask_sz_flat),
        .bid_cnt(bid_cnt), .ask_cnt(ask_cnt), .upd_valid(upd_valid),
        .cnt_drop(cnt_drop), .cnt_evict(cnt_evict), .cnt_miss(cnt_miss),
        .cnt_reject(cnt_reject)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bpx(input int i);
        return bid_px_flat[i*PX_W +: PX_W];
    endfunction
    function automatic logic [31:0] bsz(input int i);
        return bid_sz_flat[i*QTY_W +: QTY_W];
    endfunction

    // One tick: returns ready in MATCH and APPLY cycles and upd_valid in the
    // cycle after the commit edge, where the new book is visible.
    task automatic send(input logic [1:0] ty, input logic sd, input logic [31:0] q,
                        input logic [31:0] px, output logic r1, output logic r2,
                        output logic u);
        @(negedge clk);
        n_chk++;
        if (tif.tick_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: got %b want 1", tif.tick_ready);
        end
        tif.tick_valid = 1'b1; tif.tick_type = ty; tif.tick_side = sd;
        tif.tick_qty = q; tif.tick_price = px;
        @(posedge clk); #1;
        tif.tick_valid = 1'b0;
        r1 = tif.tick_ready;
        @(posedge clk); #1;
        r2 = tif.tick_ready;
        @(posedge clk); #1;
        u = upd_valid;
    endtask

    task automatic test_reset();
        tif.tick_valid = 1'b0; tif.tick_type = 2'b00; tif.tick_side = 1'b0;
        tif.tick_qty = '0; tif.tick_price = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (bid_px0 !== 32'd0) begin n_fail++; $display("FAIL reset_bid_px0: got %0h want 0", bid_px0); end
        n_chk++; if (ask_px0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_ask_px0: got %0h want ffffffff", ask_px0); end
        n_chk++; if (bid_cnt !== 4'd0 || ask_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bid_cnt, ask_cnt); end
        n_chk++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b want 0", upd_valid); end
        n_chk++; if (tif.tick_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tif.tick_ready); end
        n_chk++; if ({cnt_drop, cnt_evict, cnt_miss, cnt_reject} !== 64'd0) begin n_fail++; $display("FAIL reset_counters: got %0h want 0", {cnt_drop, cnt_evict, cnt_miss, cnt_reject}); end
        rst_n = 1'b1;
    endtask

    task automatic test_bid_sort();
        logic r1, r2, u;
        int ups = 0, rdy_hi = 0;
        logic [31:0] pxs [3] = '{32'd100, 32'd102, 32'd101};
        for (int i = 0; i < 3; i++) begin
            send(2'b00, 1'b1, 32'd10, pxs[i], r1, r2, u);
            if (r1 || r2) rdy_hi++;
            if (u) ups++;
        end
        n_chk++; if (rdy_hi !== 0) begin n_fail++; $display("FAIL sort_ready_low: got %0d ticks with ready high want 0", rdy_hi); end
        n_chk++; if (ups !== 3) begin n_fail++; $display("FAIL sort_upd_pulses: got %0d want 3", ups); end
        n_chk++; if (bpx(0) !== 32'd102 || bpx(1) !== 32'd101 || bpx(2) !== 32'd100) begin
            n_fail++; $display("FAIL sort_levels: got %0d,%0d,%0d want 102,101,100", bpx(0), bpx(1), bpx(2)); end
        n_chk++; if (bid_cnt !== 4'd3 || bpx(3) !== 32'd0) begin n_fail++; $display("FAIL sort_cnt: got cnt %0d lvl3 %0d want 3,0", bid_cnt, bpx(3)); end
        n_chk++; if (bid_sz0 !== 32'd10 || ask_cnt !== 4'd0) begin n_fail++; $display("FAIL sort_sz0: got %0d ask_cnt %0d want 10,0", bid_sz0, ask_cnt); end
    endtask

    task automatic test_ask_merge();
        logic r1, r2, u;
        send(2'b00, 1'b0, 32'd5, 32'd200, r1, r2, u);
        send(2'b00, 1'b0, 32'd7, 32'd200, r1, r2, u);
        n_chk++; if (ask_sz0 !== 32'd12 || ask_px0 !== 32'd200 || ask_cnt !== 4'd1) begin
            n_fail++; $display("FAIL merge_sz: got px %0d sz %0d cnt %0d want 200,12,1", ask_px0, ask_sz0, ask_cnt); end
        send(2'b01, 1'b0, 32'd12, 32'd200, r1, r2, u);
        n_chk++; if (ask_cnt !== 4'd0 || ask_px0 !== 32'hFFFF_FFFF || ask_sz0 !== 32'd0) begin
            n_fail++; $display("FAIL exec_remove: got cnt %0d px %0h sz %0d want 0,ffffffff,0", ask_cnt, ask_px0, ask_sz0); end
        n_chk++; if (u !== 1'b1 || bid_px0 !== 32'd102) begin n_fail++; $display("FAIL exec_upd_other: got upd %b bid_px0 %0d want 1,102", u, bid_px0); end
    endtask

    task automatic test_cancel();
        logic r1, r2, u;
        send(2'b10, 1'b1, 32'd1, 32'd150, r1, r2, u);
        n_chk++; if (cnt_miss !== 16'd1 || u !== 1'b0 || bid_cnt !== 4'd3) begin
            n_fail++; $display("FAIL cancel_miss: got miss %0d upd %b cnt %0d want 1,0,3", cnt_miss, u, bid_cnt); end
        send(2'b10, 1'b1, 32'd3, 32'd101, r1, r2, u);
        n_chk++; if (bsz(1) !== 32'd7 || bid_cnt !== 4'd3 || u !== 1'b1) begin
            n_fail++; $display("FAIL cancel_partial: got sz %0d cnt %0d upd %b want 7,3,1", bsz(1), bid_cnt, u); end
        send(2'b10, 1'b1, 32'd10, 32'd102, r1, r2, u);
        n_chk++; if (bpx(0) !== 32'd101 || bsz(0) !== 32'd7 || bpx(1) !== 32'd100 ||
                     bpx(2) !== 32'd0 || bsz(2) !== 32'd0 || bid_cnt !== 4'd2) begin
            n_fail++; $display("FAIL cancel_shift_up: got %0d/%0d %0d %0d/%0d cnt %0d want 101/7 100 0/0 cnt 2",
                               bpx(0), bsz(0), bpx(1), bpx(2), bsz(2), bid_cnt); end
    endtask

    task automatic test_saturate();
        logic r1, r2, u;
        send(2'b00, 1'b0, 32'hFFFF_FFF0, 32'd300, r1, r2, u);
        send(2'b00, 1'b0, 32'hFFFF_FFF0, 32'd300, r1, r2, u);
        n_chk++; if (ask_sz0 !== 32'hFFFF_FFFF || ask_cnt !== 4'd1) begin
            n_fail++; $display("FAIL sat_sz: got %0h cnt %0d want ffffffff,1", ask_sz0, ask_cnt); end
        send(2'b11, 1'b0, 32'd1, 32'd250, r1, r2, u);
        n_chk++; if (cnt_reject !== 16'd1 || u !== 1'b0) begin n_fail++; $display("FAIL reject_rsvd: got %0d upd %b want 1,0", cnt_reject, u); end
        send(2'b00, 1'b1, 32'd0, 32'd90, r1, r2, u);
        send(2'b00, 1'b1, 32'd4, 32'd0, r1, r2, u);
        n_chk++; if (cnt_reject !== 16'd3 || bid_cnt !== 4'd2 || ask_cnt !== 4'd1) begin
            n_fail++; $display("FAIL reject_qty_px: got %0d cnt %0d/%0d want 3,2/1", cnt_reject, bid_cnt, ask_cnt); end
    endtask

    task automatic test_evict_drop();
        logic r1, r2, u;
        logic [DEPTH*PX_W-1:0] snap;
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        n_chk++; if (upd_valid !== 1'b1 || bid_cnt !== 4'd0 || ask_cnt !== 4'd0) begin
            n_fail++; $display("FAIL clear_book: got upd %b cnt %0d/%0d want 1,0/0", upd_valid, bid_cnt, ask_cnt); end
        n_chk++; if (cnt_reject !== 16'd3 || cnt_miss !== 16'd1) begin
            n_fail++; $display("FAIL clear_keeps_counters: got %0d/%0d want 3/1", cnt_reject, cnt_miss); end
        for (int p = 1; p <= DEPTH; p++) send(2'b00, 1'b1, 32'd1, 32'(p), r1, r2, u);
        send(2'b00, 1'b1, 32'd1, 32'd9, r1, r2, u);
        n_chk++; if (bpx(0) !== 32'd9 || bpx(7) !== 32'd2 || bid_cnt !== 4'd8 || cnt_evict !== 16'd1) begin
            n_fail++; $display("FAIL evict: got lvl0 %0d lvl7 %0d cnt %0d evict %0d want 9,2,8,1", bpx(0), bpx(7), bid_cnt, cnt_evict); end
        snap = bid_px_flat;
        send(2'b00, 1'b1, 32'd1, 32'd1, r1, r2, u);
        n_chk++; if (cnt_drop !== 16'd1 || u !== 1'b0 || bid_px_flat !== snap) begin
            n_fail++; $display("FAIL drop: got drop %0d upd %b changed %b want 1,0,0", cnt_drop, u, bid_px_flat !== snap); end
    endtask

    task automatic test_abort();
        @(negedge clk);
        tif.tick_valid = 1'b1; tif.tick_type = 2'b00; tif.tick_side = 1'b1;
        tif.tick_qty = 32'd5; tif.tick_price = 32'd500;
        @(posedge clk); #1 tif.tick_valid = 1'b0;
        @(negedge clk); clear = 1'b1;
        n_chk++; if (tif.tick_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b want 0", tif.tick_ready); end
        @(posedge clk); #1 clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bid_cnt !== 4'd0 || bid_px0 !== 32'd0 || tif.tick_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_abort: got cnt %0d px %0d ready %b want 0,0,1", bid_cnt, bid_px0, tif.tick_ready); end
        @(negedge clk);
        tif.tick_valid = 1'b1; tif.tick_price = 32'd600;
        @(posedge clk); #1 tif.tick_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bid_cnt !== 4'd0 || bid_px0 !== 32'd0 || cnt_drop !== 16'd0 || upd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort: got cnt %0d px %0d drop %0d upd %b want 0,0,0,0", bid_cnt, bid_px0, cnt_drop, upd_valid); end
        n_chk++; if (tif.tick_ready !== 1'b1) begin n_fail++; $display("FAIL reset_abort_ready: got %b want 1", tif.tick_ready); end
    endtask

    initial begin
        test_reset();
        test_bid_sort();
        test_ask_merge();
        test_cancel();
        test_saturate();
        test_evict_drop();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
